// File: rtl/imem_fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-memory load/fetch sequencer.
// Imported by the top and by the load-port sub-module.
package imem_fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } seq_state_t;

    localparam int INSTR_W = 32;

    // An all-zero instruction word terminates execution.
    localparam logic [INSTR_W-1:0] HALT_WORD = 32'h0;

endpackage

// File: rtl/imem_load_port.sv
// Program-load port: valid/ready handshake, sequential word counter and the
// instruction-memory write strobe. Pulses done on the final accepted word.
module imem_load_port
    import imem_fetch_sequencer_pkg::*;
#(
    parameter int MEM_WORDS = 128,
    parameter int AW        = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               active,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_last,
    output logic               load_ready,
    output logic               mem_we,
    output logic [AW-1:0]      mem_waddr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               done
);

    localparam logic [AW-1:0] DEPTH    = AW'(MEM_WORDS);
    localparam logic [AW-1:0] LAST_IDX = AW'(MEM_WORDS - 1);

    logic [AW-1:0] count_reg;
    logic          accept;

    // Ready is held low while reset is asserted so the port never handshakes in reset.
    assign load_ready = rst_n && active && (count_reg < DEPTH);
    assign accept     = load_valid && load_ready;

    assign mem_we    = accept;
    assign mem_waddr = count_reg;
    assign mem_wdata = load_data;

    // A full memory ends the load even when the producer never raises LoadLast.
    assign done = accept && (load_last || (count_reg == LAST_IDX));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (accept) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/imem_fetch_sequencer.sv
// Loads a program into instruction memory, then drives a word-indexed PC and
// registers one fetched instruction per cycle, with stall, redirect and halt.
module imem_fetch_sequencer
    import imem_fetch_sequencer_pkg::*;
#(
    parameter int MEM_WORDS = 128,
    parameter int RESET_PC  = 0,
    parameter int AW        = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Start,
    input  logic               LoadValid,
    output logic               LoadReady,
    input  logic [INSTR_W-1:0] LoadData,
    input  logic               LoadLast,
    output logic               MemWriteEnable,
    output logic [AW-1:0]      MemWriteAddr,
    output logic [INSTR_W-1:0] MemWriteData,
    output logic [AW-1:0]      Address,
    input  logic [INSTR_W-1:0] ReadData1,
    input  logic               Stall,
    input  logic               BranchTaken,
    input  logic [AW-1:0]      BranchTarget,
    output logic [INSTR_W-1:0] InstrOut,
    output logic [AW-1:0]      InstrPC,
    output logic               InstrValid,
    output logic               Halted
);

    localparam logic [AW-1:0] PC_START = AW'(RESET_PC);
    localparam logic [AW-1:0] DEPTH    = AW'(MEM_WORDS);

    seq_state_t         state_reg;
    logic [AW-1:0]      pc_reg;
    logic [INSTR_W-1:0] instr_reg;
    logic [AW-1:0]      instr_pc_reg;
    logic               valid_reg;
    logic               halted_reg;
    logic               load_done;

    imem_load_port #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_load_port (
        .clk        (clk),
        .rst_n      (rst_n),
        .active     (state_reg == ST_LOAD),
        .load_valid (LoadValid),
        .load_data  (LoadData),
        .load_last  (LoadLast),
        .load_ready (LoadReady),
        .mem_we     (MemWriteEnable),
        .mem_waddr  (MemWriteAddr),
        .mem_wdata  (MemWriteData),
        .done       (load_done)
    );

    assign Address    = pc_reg;
    assign InstrOut   = instr_reg;
    assign InstrPC    = instr_pc_reg;
    assign InstrValid = valid_reg;
    assign Halted     = halted_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_LOAD;
            pc_reg       <= PC_START;
            instr_reg    <= '0;
            instr_pc_reg <= '0;
            valid_reg    <= 1'b0;
            halted_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_LOAD: begin
                    if (Start || load_done) begin
                        state_reg <= ST_RUN;
                        pc_reg    <= PC_START;
                        valid_reg <= 1'b0;
                    end
                end

                ST_RUN: begin
                    // Redirect outranks stall so a taken branch is never lost.
                    if (BranchTaken) begin
                        pc_reg    <= BranchTarget;
                        valid_reg <= 1'b0;
                    end else if (!Stall) begin
                        if ((pc_reg >= DEPTH) || (ReadData1 == HALT_WORD)) begin
                            state_reg  <= ST_HALT;
                            halted_reg <= 1'b1;
                            valid_reg  <= 1'b0;
                        end else begin
                            instr_reg    <= ReadData1;
                            instr_pc_reg <= pc_reg;
                            valid_reg    <= 1'b1;
                            pc_reg       <= pc_reg + 1'b1;
                        end
                    end
                end

                ST_HALT: begin
                    valid_reg <= 1'b0;
                    if (Start) begin
                        state_reg  <= ST_RUN;
                        halted_reg <= 1'b0;
                        pc_reg     <= PC_START;
                    end
                end

                default: begin
                    state_reg  <= ST_LOAD;
                    valid_reg  <= 1'b0;
                    halted_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Self-checking bench: vector table, directed corner sequences and random
// traffic, all compared against a cycle-level behavioural model of the sequencer.
module tb_imem_fetch_sequencer;

    localparam int MEM_WORDS = 128;
    localparam int AW        = 32;
    localparam logic [AW-1:0] DEPTH = 32'd128;

    logic            clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            Start;
    logic            LoadValid;
    logic            LoadReady;
    logic [31:0]     LoadData;
    logic            LoadLast;
    logic            MemWriteEnable;
    logic [AW-1:0]   MemWriteAddr;
    logic [31:0]     MemWriteData;
    logic [AW-1:0]   Address;
    logic [31:0]     ReadData1;
    logic            Stall;
    logic            BranchTaken;
    logic [AW-1:0]   BranchTarget;
    logic [31:0]     InstrOut;
    logic [AW-1:0]   InstrPC;
    logic            InstrValid;
    logic            Halted;

    imem_fetch_sequencer #(
        .MEM_WORDS (MEM_WORDS),
        .RESET_PC  (0),
        .AW        (AW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .Start          (Start),
        .LoadValid      (LoadValid),
        .LoadReady      (LoadReady),
        .LoadData       (LoadData),
        .LoadLast       (LoadLast),
        .MemWriteEnable (MemWriteEnable),
        .MemWriteAddr   (MemWriteAddr),
        .MemWriteData   (MemWriteData),
        .Address        (Address),
        .ReadData1      (ReadData1),
        .Stall          (Stall),
        .BranchTaken    (BranchTaken),
        .BranchTarget   (BranchTarget),
        .InstrOut       (InstrOut),
        .InstrPC        (InstrPC),
        .InstrValid     (InstrValid),
        .Halted         (Halted)
    );

    // Instruction memory: synchronous write, asynchronous read.
    logic [31:0] mem [0:MEM_WORDS-1];
    logic        mem_clear;

    always_ff @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
        end else if (MemWriteEnable && (MemWriteAddr < DEPTH)) begin
            mem[MemWriteAddr[6:0]] <= MemWriteData;
        end
    end

    assign ReadData1 = (Address < DEPTH) ? mem[Address[6:0]] : 32'hDEAD_BEEF;

    // Behavioural model: mode 0 = loading, 1 = running, 2 = halted.
    int          m_mode;
    int          m_cnt;
    logic [31:0] m_pc;
    logic [31:0] m_iout;
    logic [31:0] m_ipc;
    logic        m_ival;
    logic [31:0] ref_mem [0:MEM_WORDS-1];

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    task automatic checkb(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b, want %b", name, $time, act, exp);
        end
    endtask

    task automatic set_idle();
        Start        = 1'b0;
        LoadValid    = 1'b0;
        LoadData     = '0;
        LoadLast     = 1'b0;
        Stall        = 1'b0;
        BranchTaken  = 1'b0;
        BranchTarget = '0;
    endtask

    task automatic model_step();
        logic acc;
        logic stop;
        if (!rst_n) begin
            m_mode = 0; m_cnt = 0; m_pc = 0;
            m_iout = 0; m_ipc = 0; m_ival = 1'b0;
        end else if (m_mode == 0) begin
            acc = LoadValid && (m_cnt < MEM_WORDS);
            if (acc) begin
                ref_mem[m_cnt] = LoadData;
                m_cnt++;
            end
            if (Start || (acc && (LoadLast || m_cnt == MEM_WORDS))) begin
                m_mode = 1; m_pc = 0; m_ival = 1'b0;
            end
        end else if (m_mode == 1) begin
            if (BranchTaken) begin
                m_pc = BranchTarget; m_ival = 1'b0;
            end else if (!Stall) begin
                stop = (m_pc >= MEM_WORDS);
                if (!stop) stop = (ref_mem[m_pc[6:0]] == 32'h0);
                if (stop) begin
                    m_mode = 2; m_ival = 1'b0;
                end else begin
                    m_iout = ref_mem[m_pc[6:0]];
                    m_ipc  = m_pc;
                    m_ival = 1'b1;
                    m_pc   = m_pc + 1;
                end
            end
        end else begin
            m_ival = 1'b0;
            if (Start) begin
                m_mode = 1; m_pc = 0;
            end
        end
    endtask

    // One clock: check combinational load outputs, clock, check registered outputs.
    task automatic cycle();
        logic exp_ready;
        #1;
        exp_ready = rst_n && (m_mode == 0) && (m_cnt < MEM_WORDS);
        checkb("LoadReady", LoadReady, exp_ready);
        checkb("MemWriteEnable", MemWriteEnable, exp_ready && LoadValid);
        if (exp_ready && LoadValid) begin
            check("MemWriteAddr", MemWriteAddr, 32'(m_cnt));
            check("MemWriteData", MemWriteData, LoadData);
        end
        if (MemWriteEnable) begin
            n_writes++;
            $display("write  addr=%0d data=%h", MemWriteAddr, MemWriteData);
        end
        @(posedge clk);
        model_step();
        #1;
        checkb("InstrValid", InstrValid, m_ival);
        checkb("Halted", Halted, m_mode == 2);
        check("Address", Address, m_pc);
        check("InstrOut", InstrOut, m_iout);
        check("InstrPC", InstrPC, m_ipc);
        if (InstrValid) $display("fetch  pc=%0d instr=%h", InstrPC, InstrOut);
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        start;
        logic        lv;
        logic [31:0] ld;
        logic        ll;
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        ev;
        logic [31:0] eipc;
        logic        eh;
    } vec_t;

    vec_t vecs [10];

    initial begin
        // 4-word program, LoadLast on the 4th; word 4 is zero and halts the run.
        vecs[0] = '{1'b0, 1'b1, 32'hA000_0000, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'hA000_0001, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 32'hA000_0002, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 32'hA000_0003, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd2, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd3, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd3, 1'b1};
        vecs[9] = '{1'b0, 1'b1, 32'h5555_5555, 1'b0, 1'b0, 1'b1, 32'd7, 1'b0, 32'd3, 1'b1};

        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = '0;
        mem_clear = 1'b1;
        m_mode = 0; m_cnt = 0; m_pc = 0; m_iout = 0; m_ipc = 0; m_ival = 1'b0;
        do_reset();
        mem_clear = 1'b0;

        // ---- table-driven basic load + run ----
        n_writes = 0;
        for (int i = 0; i < 10; i++) begin
            set_idle();
            Start = vecs[i].start; LoadValid = vecs[i].lv; LoadData = vecs[i].ld;
            LoadLast = vecs[i].ll; Stall = vecs[i].stall;
            BranchTaken = vecs[i].br; BranchTarget = vecs[i].tgt;
            cycle();
            checkb("vec_valid", InstrValid, vecs[i].ev);
            checkb("vec_halted", Halted, vecs[i].eh);
            if (vecs[i].ev) check("vec_instr_pc", InstrPC, vecs[i].eipc);
        end
        check("vec_write_count", 32'(n_writes), 32'd4);

        // ---- toggling LoadValid, then stall / branch / halt / restart ----
        do_reset();
        begin
            int w = 0;
            for (int k = 0; k < 60 && w < 12; k++) begin
                set_idle();
                LoadValid = (k % 2 == 0);
                LoadData  = 32'h100 + 32'(w);
                LoadLast  = (w == 11);
                cycle();
                if (LoadValid) w++;
            end
        end
        set_idle();
        cycle();
        cycle();
        check("pre_stall_pc", InstrPC, 32'd1);
        check("pre_stall_addr", Address, 32'd2);
        for (int k = 0; k < 3; k++) begin
            Stall = 1'b1;
            cycle();
            check("stall_instr_pc", InstrPC, 32'd1);
            check("stall_addr", Address, 32'd2);
            check("stall_instr", InstrOut, 32'h101);
        end
        set_idle();
        cycle();
        check("post_stall_pc", InstrPC, 32'd2);
        check("post_stall_instr", InstrOut, 32'h102);
        cycle(); cycle(); cycle();
        check("pre_branch_pc", InstrPC, 32'd5);
        checkb("pre_branch_valid", InstrValid, 1'b1);
        BranchTaken = 1'b1; BranchTarget = 32'd10;
        cycle();
        checkb("flush_valid", InstrValid, 1'b0);
        set_idle();
        cycle();
        check("branch_instr_pc", InstrPC, 32'd10);
        check("branch_instr", InstrOut, 32'h10A);
        BranchTaken = 1'b1; BranchTarget = 32'd3; Stall = 1'b1;
        cycle();
        checkb("br_stall_flush", InstrValid, 1'b0);
        check("br_stall_addr", Address, 32'd3);
        set_idle();
        cycle();
        check("br_stall_instr_pc", InstrPC, 32'd3);
        BranchTaken = 1'b1; BranchTarget = 32'd200;
        cycle();
        set_idle();
        cycle();
        checkb("oor_halted", Halted, 1'b1);
        LoadValid = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'd5;
        cycle();
        check("halt_ignores_addr", Address, 32'd200);
        set_idle();
        Start = 1'b1;
        cycle();
        checkb("restart_halted", Halted, 1'b0);
        check("restart_addr", Address, 32'd0);
        set_idle();
        cycle();
        check("restart_instr_pc", InstrPC, 32'd0);
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check("rst_addr", Address, 32'd0);
        checkb("rst_valid", InstrValid, 1'b0);
        checkb("rst_halted", Halted, 1'b0);
        cycle();
        Start = 1'b1;
        cycle();
        set_idle();
        cycle();
        check("kept_instr_pc", InstrPC, 32'd0);
        check("kept_instr", InstrOut, 32'h100);

        // ---- overfill: 130 words offered, 128 accepted ----
        do_reset();
        n_writes = 0;
        for (int k = 0; k < 130; k++) begin
            set_idle();
            LoadValid = 1'b1;
            LoadData  = $urandom | 32'h1;
            cycle();
        end
        check("fill_write_count", 32'(n_writes), 32'd128);
        set_idle();
        for (int k = 0; k < 130; k++) cycle();
        checkb("fill_halted", Halted, 1'b1);
        check("fill_halt_addr", Address, 32'd128);

        // ---- random traffic ----
        for (int r = 0; r < 4; r++) begin
            int len;
            int sent;
            len  = $urandom_range(1, 40);
            sent = 0;
            do_reset();
            for (int k = 0; k < 200 && m_mode == 0; k++) begin
                set_idle();
                LoadValid = ($urandom_range(0, 1) == 1);
                LoadData  = ($urandom_range(0, 9) == 0) ? 32'h0 : ($urandom | 32'h1);
                LoadLast  = (sent == len - 1);
                Start     = ($urandom_range(0, 49) == 0);
                cycle();
                if (LoadValid) sent++;
            end
            checkb("rand_load_done", m_mode != 0, 1'b1);
            for (int k = 0; k < 150; k++) begin
                set_idle();
                Stall        = ($urandom_range(0, 3) == 0);
                BranchTaken  = ($urandom_range(0, 9) == 0);
                BranchTarget = 32'($urandom_range(0, 135));
                Start        = ($urandom_range(0, 19) == 0);
                LoadValid    = ($urandom_range(0, 1) == 1);
                LoadData     = $urandom;
                cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_fetch_sequencer.md
Name: imem_fetch_sequencer

Overview:
- Controls the single-cycle core's instruction memory: loads a program into it, then sequences instruction fetch.
- After reset it accepts program words over a valid/ready load port and writes them to consecutive word indices.
- It then runs a word-indexed PC through the async-read instruction memory and registers one fetched instruction per cycle for the datapath.
- It handles stall, branch redirect (with flush) and halt on an all-zero instruction or an out-of-range PC.

Parameters:
- MEM_WORDS, 128, instruction memory depth in 32-bit words.
- RESET_PC, 0, word index of the first fetch after load or restart.
- AW, 32, PC / address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- Start  in  1  pulse: skip or abort load, or restart from HALT; fetch begins at RESET_PC.
- LoadValid  in  1  load word present.
- LoadReady  out  1  block accepts a load word.
- LoadData  in  32  program word.
- LoadLast  in  1  final word of the program (qualified by LoadValid&LoadReady).
- MemWriteEnable  out  1  instruction memory write strobe.
- MemWriteAddr  out  AW  word index to write.
- MemWriteData  out  32  word to write.
- Address  out  AW  word index to the memory read port (equals PC).
- ReadData1  in  32  async read data from the memory.
- Stall  in  1  datapath cannot accept a new instruction.
- BranchTaken  in  1  redirect fetch.
- BranchTarget  in  AW  redirect word index.
- InstrOut  out  32  registered fetched instruction.
- InstrPC  out  AW  word index of InstrOut.
- InstrValid  out  1  InstrOut is live.
- Halted  out  1  sequencer is in HALT.

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low.
- Reset state: LOAD; PC=RESET_PC; load counter=0; InstrOut=0; InstrPC=0; InstrValid=0; Halted=0; LoadReady=0; MemWriteEnable=0.
- Addressing: word-indexed, so a sequential fetch is PC+1. Address is driven by the PC register combinationally.
- FSM states: LOAD, RUN, HALT.

LOAD:
- LoadReady=1 while the load counter is below MEM_WORDS.
- On LoadValid&LoadReady, the write strobe is combinational in the same cycle:
  - MemWriteEnable=1.
  - MemWriteAddr=counter.
  - MemWriteData=LoadData.
  - The counter increments.
- Leave for RUN (PC=RESET_PC, InstrValid=0) when either:
  - the accepted word has LoadLast=1, or
  - the accepted word is at counter=MEM_WORDS-1 (memory full; LoadLast is ignored).
- Start in LOAD goes to RUN next cycle; a word offered in that same cycle is still written.
- Memory is never written outside LOAD.

RUN, per cycle, in priority order:
1. BranchTaken: PC<=BranchTarget; InstrValid<=0 (flush). This wins over Stall.
2. Stall: PC, InstrOut, InstrPC and InstrValid all hold.
3. PC>=MEM_WORDS or ReadData1==0: go to HALT; InstrValid<=0; PC holds.
4. Otherwise: InstrOut<=ReadData1; InstrPC<=PC; InstrValid<=1; PC<=PC+1.
- Fetch-to-InstrValid latency is 1 cycle. After a branch, the first valid instruction appears 2 cycles after the BranchTaken cycle.
- An out-of-range BranchTarget is legal; it halts on the next non-stalled cycle.

HALT:
- Halted=1; InstrValid=0; all inputs ignored except Start.
- Start returns to RUN with PC=RESET_PC. Memory contents are kept (no reload).

Other rules:
- Reset asserted in any state returns to the reset state on that edge. Memory contents written so far are not cleared.
- PC arithmetic is unsigned AW-bit. PC+1 wrap at 2^AW is unreachable because of the MEM_WORDS check.

Decomposition:
- Shared package holds: the state enum (LOAD, RUN, HALT), the INSTR_W=32 constant, and the HALT_WORD=32'h0 constant.
- One natural sub-module: imem_load_port. It contains the load counter, the valid/ready logic and the write-strobe generation, and outputs a done pulse to the FSM.
- PC, fetch register and FSM stay in the top module.

Test Plan:
- Load 4 words (LoadLast on the 4th), memory model attached:
  - 4 write strobes to addresses 0..3.
  - RUN begins.
  - InstrValid rises 1 cycle later with InstrPC=0, 1, 2, 3.
  - HALT when word 4 (zero) is read.
- Load with LoadValid toggling every other cycle: writes occur only on handshake cycles; addresses remain contiguous 0..N-1.
- Stall held 3 cycles at PC=2: InstrOut/InstrPC/PC frozen; the next fetch is PC=2 content, with no skip or duplicate.
- BranchTaken with target 10 while InstrPC=5 valid:
  - InstrValid=0 the next cycle.
  - The following cycle InstrPC=10.
  - BranchTaken together with Stall still redirects.
- Offer 130 words with MEM_WORDS=128:
  - Exactly 128 writes, to addresses 0..127.
  - LoadReady=0 after the 128th.
  - Auto-enters RUN.
- rst_n low in mid-RUN: next cycle LOAD, PC=0, InstrValid=0. Then Start runs the preserved program from 0. Halted restart via Start also fetches from RESET_PC.
